// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a credit-managed prefetch FIFO.
// Sequential fetches are buffered with their PCs; a taken branch flushes the queue and drops in-flight responses.
module if_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instruction
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic [CW:0]     in_use;
  logic            accept;
  logic            discarding;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_aligned;

  // Every accepted request already owns a FIFO slot, so responses can never overflow.
  assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !branch_taken && (in_use < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign discarding     = (discard_cnt != '0);
  assign push           = imem_rsp_valid && !branch_taken && !discarding;
  assign pop            = if_valid && !stall;
  assign target_aligned = branch_target & ~XLEN'(3);

  // Head is read straight from registered storage; an empty queue shows the next expected PC and a NOP.
  assign if_valid    = (fifo_count != '0);
  assign pc          = if_valid ? pc_mem[rd_ptr]  : rsp_pc;
  assign instruction = if_valid ? ins_mem[rd_ptr] : NOP;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (accept && !imem_rsp_valid)
        outstanding <= outstanding + CW'(1);
      else if (!accept && imem_rsp_valid)
        outstanding <= outstanding - CW'(1);

      if (branch_taken) begin
        // Responses still in flight belong to the old path; the one arriving now is dropped too.
        fetch_pc    <= target_aligned;
        rsp_pc      <= target_aligned;
        discard_cnt <= outstanding - CW'(imem_rsp_valid);
        fifo_count  <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + XLEN'(4);

        if (imem_rsp_valid && discarding)
          discard_cnt <= discard_cnt - CW'(1);

        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
          wr_ptr <= wr_ptr + PW'(1);
        end

        if (pop)
          rd_ptr <= rd_ptr + PW'(1);

        if (push && !pop)
          fifo_count <= fifo_count + CW'(1);
        else if (!push && pop)
          fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  // NOTE: payload storage has no reset; fifo_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= rsp_pc;
      ins_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order memory model of programmable latency.
// Instruction memory returns addr>>2, so every presented instruction must equal pc>>2.
module tb_if_prefetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] pc;
  logic [31:0] instruction;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mem_req_t    q[$];
  int          cyc;
  int          lat;
  int          acc_count;
  logic [31:0] acc_addr_last;
  logic        wait_last;
  logic [31:0] wait_addr_last;
  logic [31:0] exp_pc;

  if_prefetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .pc            (pc),
    .instruction   (instruction)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the request/response handshake before the edge, then advances the memory model one cycle.
  task automatic step();
    logic        acc;
    logic        waiting;
    logic        presented;
    logic [31:0] a;
    #2;
    acc       = imem_req_valid && imem_req_ready;
    waiting   = imem_req_valid && !imem_req_ready;
    a         = imem_req_addr;
    presented = imem_rsp_valid;
    @(posedge clk);
    #1;
    if (presented && q.size() > 0) q.delete(0);
    if (acc) begin
      q.push_back('{addr: a, due: cyc + lat});
      acc_count++;
      acc_addr_last = a;
    end
    wait_last      = waiting;
    wait_addr_last = a;
    cyc++;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = q[0].addr >> 2;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    cyc       = 0;
    acc_count = 0;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    lat            = 1;
    cyc            = 0;
    acc_count      = 0;
    acc_addr_last  = '0;
    wait_last      = 1'b0;
    wait_addr_last = '0;

    // Reset state and zero-wait streaming
    repeat (3) @(posedge clk);
    #1;
    check("reset_if_valid", 32'(if_valid), 32'd0);
    check("reset_pc", pc, 32'h0);
    check("reset_instruction", instruction, 32'h0000_0013);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    step();
    check("cycle1_if_valid", 32'(if_valid), 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_pc", pc, 32'(4 * k));
      check("stream_ins", instruction, 32'(k));
      if (k < 2) step();
    end

    // Stall for 10 cycles once pc=8; FIFO fills with 8,C,10,14 and fetching stops
    stall     = 1'b1;
    acc_count = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_hold_valid", 32'(if_valid), 32'd1);
      check("stall_hold_pc", pc, 32'h8);
    end
    check("stall_accept_count", 32'(acc_count), 32'd2);
    check("stall_last_accept_addr", acc_addr_last, 32'h14);
    check("stall_req_valid_off", 32'(imem_req_valid), 32'd0);
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("release_valid", 32'(if_valid), 32'd1);
      check("release_pc", pc, 32'h8 + 32'(4 * k));
      check("release_ins", instruction, 32'h2 + 32'(k));
      step();
    end

    // Branch with three requests in flight on a 3-cycle memory
    do_reset();
    lat = 3;
    step();
    step();
    step();
    check("pre_branch_req_valid", 32'(imem_req_valid), 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    #1;
    check("branch_blocks_req", 32'(imem_req_valid), 32'd0);
    step();
    branch_taken = 1'b0;
    check("branch_redirect_addr", imem_req_addr, 32'h20);
    for (int k = 0; k < 4; k++) begin
      check("branch_discard_no_valid", 32'(if_valid), 32'd0);
      step();
    end
    check("branch_first_valid", 32'(if_valid), 32'd1);
    check("branch_first_pc", pc, 32'h20);
    check("branch_first_ins", instruction, 32'h8);
    step();
    check("branch_second_pc", pc, 32'h24);
    check("branch_second_ins", instruction, 32'h9);

    // Branch coincident with stall and a response; unaligned target
    do_reset();
    lat = 1;
    step();
    step();
    check("coinc_pc0", pc, 32'h0);
    step();
    check("coinc_pc4", pc, 32'h4);
    check("coinc_rsp_present", 32'(imem_rsp_valid), 32'd1);
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    #1;
    check("coinc_req_blocked", 32'(imem_req_valid), 32'd0);
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("coinc_flushed", 32'(if_valid), 32'd0);
    check("coinc_nop", instruction, 32'h0000_0013);
    check("coinc_fetch_addr", imem_req_addr, 32'h40);
    #1;
    check("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    check("coinc_still_empty", 32'(if_valid), 32'd0);
    step();
    check("coinc_first_valid", 32'(if_valid), 32'd1);
    check("coinc_first_pc", pc, 32'h40);
    check("coinc_first_ins", instruction, 32'h10);
    step();
    check("coinc_second_pc", pc, 32'h44);

    // Random memory wait states and random decode stalls
    exp_pc = 32'h44;
    for (int i = 0; i < 80; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      imem_req_ready = 1'($urandom_range(0, 1));
      if (if_valid) begin
        check("rand_pc", pc, exp_pc);
        check("rand_ins", instruction, exp_pc >> 2);
        if (!stall) exp_pc = exp_pc + 32'd4;
      end
      step();
      check("rand_outstanding_le_depth", 32'(q.size() <= 4), 32'd1);
      if (wait_last && imem_req_valid)
        check("rand_addr_stable", imem_req_addr, wait_addr_last);
    end
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    check("rand_progress", 32'(exp_pc >= 32'h44 + 32'd40), 32'd1);

    // Asynchronous reset pulse while three entries are buffered
    do_reset();
    lat = 1;
    step();
    step();
    check("areset_head_pc", pc, 32'h0);
    stall = 1'b1;
    step();
    step();
    check("areset_pre_valid", 32'(if_valid), 32'd1);
    check("areset_pre_pc", pc, 32'h0);
    check("areset_pre_credit_full", 32'(imem_req_valid), 32'd0);
    #2;
    rst            = 1'b1;
    stall          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    q.delete();
    #1;
    check("areset_if_valid", 32'(if_valid), 32'd0);
    check("areset_pc", pc, 32'h0);
    check("areset_instruction", instruction, 32'h0000_0013);
    #1;
    rst = 1'b0;
    cyc = 0;
    #1;
    check("areset_req_valid", 32'(imem_req_valid), 32'd1);
    check("areset_req_addr", imem_req_addr, 32'h0);
    step();
    check("areset_cycle1_empty", 32'(if_valid), 32'd0);
    step();
    check("areset_refetch_pc0", pc, 32'h0);
    check("areset_refetch_valid", 32'(if_valid), 32'd1);
    step();
    check("areset_refetch_pc4", pc, 32'h4);
    check("areset_refetch_ins", instruction, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
